// File: rtl/typing_pkg.sv
// Shared types and codes for the typing-test controller.
// Holds the state encoding, the datapath select codes and the control-word decode.
package typing_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ARM       = 4'd1,
        ST_WAIT_KEY  = 4'd2,
        ST_START_SW  = 4'd3,
        ST_ECHO_OK   = 4'd4,
        ST_ECHO_BAD  = 4'd5,
        ST_TX_GO     = 4'd6,
        ST_TX_WAIT   = 4'd7,
        ST_CHECK_END = 4'd8,
        ST_FINISH    = 4'd9,
        ST_DONE      = 4'd10
    } state_t;

    localparam logic [1:0] ADDR_CLR = 2'd0;
    localparam logic [1:0] ADDR_INC = 2'd1;

    localparam logic [1:0] OUT_ZERO = 2'd0;
    localparam logic [1:0] OUT_ROM  = 2'd1;
    localparam logic [1:0] OUT_RX   = 2'd2;
    localparam logic [1:0] OUT_ERR  = 2'd3;

    localparam logic [7:0] ERR_CHAR   = 8'h2A;
    localparam logic [7:0] ENTER_CHAR = 8'h0D;

    typedef struct packed {
        logic       en_curr_addr;
        logic [1:0] s_curr_addr;
        logic       en_stopwatch_rst;
        logic       s_stopwatch_rst;
        logic       en_stopwatch_start;
        logic       s_stopwatch_start;
        logic       en_out_byte;
        logic [1:0] s_out_byte;
        logic       en_uart_tx_go;
        logic       s_uart_tx_go;
        logic       game_active;
        logic       game_done;
    } ctrl_t;

    // Moore decode: every datapath control is a function of the state alone.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_IDLE: begin
                c.en_stopwatch_rst   = 1'b1;
                c.s_stopwatch_rst    = 1'b1;
                c.en_curr_addr       = 1'b1;
                c.s_curr_addr        = ADDR_CLR;
                c.en_stopwatch_start = 1'b1;
                c.s_stopwatch_start  = 1'b0;
            end
            ST_ARM: begin
                c.en_stopwatch_rst = 1'b1;
                c.s_stopwatch_rst  = 1'b0;
            end
            ST_START_SW: begin
                c.en_stopwatch_start = 1'b1;
                c.s_stopwatch_start  = 1'b1;
            end
            ST_ECHO_OK: begin
                c.en_out_byte  = 1'b1;
                c.s_out_byte   = OUT_RX;
                c.en_curr_addr = 1'b1;
                c.s_curr_addr  = ADDR_INC;
            end
            ST_ECHO_BAD: begin
                c.en_out_byte = 1'b1;
                c.s_out_byte  = OUT_ERR;
            end
            ST_TX_GO: begin
                c.en_uart_tx_go = 1'b1;
                c.s_uart_tx_go  = 1'b1;
            end
            ST_TX_WAIT: begin
                c.en_uart_tx_go = 1'b1;
                c.s_uart_tx_go  = 1'b0;
            end
            ST_FINISH: begin
                c.en_stopwatch_start = 1'b1;
                c.s_stopwatch_start  = 1'b0;
            end
            default: c = '0;
        endcase
        c.game_active = (s >= ST_WAIT_KEY) && (s <= ST_CHECK_END);
        c.game_done   = (s == ST_DONE);
        return c;
    endfunction

endpackage

// File: rtl/tx_watchdog.sv
// Bounds the wait for UART TX completion; counts while enabled, clears otherwise.
// expired_o fires on the cycle the count steps to TX_TIMEOUT_CYCLES-1 (needs >= 2).
module tx_watchdog #(
    parameter int unsigned TX_TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TX_TIMEOUT_CYCLES > 2) ? $clog2(TX_TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_PRE = CW'(TX_TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CNT_PRE);

endmodule

// File: rtl/typing_controller.sv
// Moore FSM sequencing the typing-test datapath: address, stopwatch, echo byte, UART TX.
// Optional mistype counter enabled by TYPING_ERR_COUNT_EN; otherwise err_count reads 0.
module typing_controller
    import typing_pkg::*;
#(
    parameter int unsigned TX_TIMEOUT_CYCLES = 20000,
    parameter int unsigned ERR_W             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_eq_0,
    input  logic             uart_pressed_eq_1,
    input  logic             start_of_game,
    input  logic             rom_eq_uart,
    input  logic             end_of_game,
    input  logic             stopwatch_start_eq_0_and_rom_eq_0,
    input  logic             stopwatch_start_eq_0_and_rom_ne_0,
    input  logic             tx_done,
    output logic             en_curr_addr,
    output logic [1:0]       s_curr_addr,
    output logic             en_stopwatch_rst,
    output logic             s_stopwatch_rst,
    output logic             en_stopwatch_start,
    output logic             s_stopwatch_start,
    output logic             en_out_byte,
    output logic [1:0]       s_out_byte,
    output logic             en_uart_tx_go,
    output logic             s_uart_tx_go,
    output logic             game_active,
    output logic             game_done,
    output logic [ERR_W-1:0] err_count,
    output logic             tx_timeout
);

    state_t state_q, state_d;
    logic   tx_timeout_q;
    logic   wd_expired;
    ctrl_t  ctrl;

    tx_watchdog #(
        .TX_TIMEOUT_CYCLES(TX_TIMEOUT_CYCLES)
    ) u_tx_watchdog (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ST_TX_WAIT),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (uart_pressed_eq_1 && start_of_game) state_d = ST_ARM;
            ST_ARM:       state_d = ST_WAIT_KEY;
            ST_WAIT_KEY: begin
                if (uart_pressed_eq_1) begin
                    if (stopwatch_start_eq_0_and_rom_eq_0)      state_d = ST_START_SW;
                    else if (stopwatch_start_eq_0_and_rom_ne_0) state_d = ST_ECHO_BAD;
                    else if (rom_eq_uart)                       state_d = ST_ECHO_OK;
                    else                                        state_d = ST_ECHO_BAD;
                end
            end
            ST_START_SW:  state_d = ST_ECHO_OK;
            ST_ECHO_OK:   state_d = ST_TX_GO;
            ST_ECHO_BAD:  state_d = ST_TX_GO;
            ST_TX_GO:     state_d = ST_TX_WAIT;
            ST_TX_WAIT:   if (tx_done || wd_expired) state_d = ST_CHECK_END;
            ST_CHECK_END: state_d = end_of_game ? ST_FINISH : ST_WAIT_KEY;
            ST_FINISH:    state_d = ST_DONE;
            ST_DONE:      if (uart_pressed_eq_1 && start_of_game) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // A user game-reset request wins over every other transition.
        if (!reset_eq_0) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ARM) begin
                tx_timeout_q <= 1'b0;
            end else if (wd_expired) begin
                tx_timeout_q <= 1'b1;
            end
        end
    end

`ifdef TYPING_ERR_COUNT_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (state_q == ST_ARM) begin
            err_q <= '0;
        end else if ((state_q == ST_ECHO_BAD) && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

    assign ctrl               = decode_state(state_q);
    assign en_curr_addr       = ctrl.en_curr_addr;
    assign s_curr_addr        = ctrl.s_curr_addr;
    assign en_stopwatch_rst   = ctrl.en_stopwatch_rst;
    assign s_stopwatch_rst    = ctrl.s_stopwatch_rst;
    assign en_stopwatch_start = ctrl.en_stopwatch_start;
    assign s_stopwatch_start  = ctrl.s_stopwatch_start;
    assign en_out_byte        = ctrl.en_out_byte;
    assign s_out_byte         = ctrl.s_out_byte;
    assign en_uart_tx_go      = ctrl.en_uart_tx_go;
    assign s_uart_tx_go       = ctrl.s_uart_tx_go;
    assign game_active        = ctrl.game_active;
    assign game_done          = ctrl.game_done;
    assign tx_timeout         = tx_timeout_q;

endmodule

// File: doc/typing_controller.md
Name: typing_controller

Overview:
- Moore FSM that sequences the typing-test datapath.
- Consumes the datapath status flags plus UART-TX completion.
- Drives every datapath enable/select pair: current ROM address, stopwatch reset/start, output byte mux, UART-TX go.
- Sits between the top level and the datapath; one instance per game.

Parameters:
- TX_TIMEOUT_CYCLES, 20000, max cycles waited for tx_done after a TX pulse (> one 8N1 byte at 115200 baud / 100 MHz).
- ERR_W, 8, width of error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- reset_eq_0  in  1  high while user game-reset request is inactive
- uart_pressed_eq_1  in  1  single-cycle strobe, new RX byte valid
- start_of_game  in  1  RX byte is Enter (8'h0D)
- rom_eq_uart  in  1  RX byte equals ROM char at current address
- end_of_game  in  1  ROM char at current address is the text terminator
- stopwatch_start_eq_0_and_rom_eq_0  in  1  stopwatch idle and RX matches ROM
- stopwatch_start_eq_0_and_rom_ne_0  in  1  stopwatch idle and RX mismatches ROM
- tx_done  in  1  single-cycle strobe from UART TX, byte finished
- en_curr_addr  out  1  address register enable
- s_curr_addr  out  2  0=clear, 1=increment, 2/3 unused (driven 0)
- en_stopwatch_rst  out  1  stopwatch reset enable
- s_stopwatch_rst  out  1  1=hold reset, 0=release
- en_stopwatch_start  out  1  stopwatch run enable
- s_stopwatch_start  out  1  1=run, 0=stop
- en_out_byte  out  1  output byte register enable
- s_out_byte  out  2  0=8'h00, 1=ROM char, 2=RX byte, 3=error char 8'h2A
- en_uart_tx_go  out  1  TX-go register enable
- s_uart_tx_go  out  1  TX-go value
- game_active  out  1  high in WAIT_KEY..CHECK_END
- game_done  out  1  high in DONE
- err_count  out  ERR_W  mistyped characters this game
- tx_timeout  out  1  sticky; set on any TX watchdog expiry

Behaviour:
- Reset: state IDLE, err_count 0, tx_timeout 0, watchdog 0.
- Reset output values: every en_* and s_* output 0 except IDLE decode.
- Outputs are pure decode of the state register; no Mealy paths. One state per cycle unless waiting.
- IDLE:
  - Outputs: en/s_stopwatch_rst=1/1, en_curr_addr=1 with s=0, en/s_stopwatch_start=1/0.
  - Transition: uart_pressed_eq_1 & start_of_game -> ARM.
- ARM:
  - Outputs: en/s_stopwatch_rst=1/0; clears err_count and tx_timeout.
  - Transition: -> WAIT_KEY.
- WAIT_KEY: on uart_pressed_eq_1, priority order:
  - stopwatch_start_eq_0_and_rom_eq_0 -> START_SW
  - stopwatch_start_eq_0_and_rom_ne_0 -> ECHO_BAD
  - rom_eq_uart -> ECHO_OK
  - otherwise -> ECHO_BAD
- START_SW: en/s_stopwatch_start=1/1 -> ECHO_OK.
- ECHO_OK: en_out_byte=1, s_out_byte=2; en_curr_addr=1, s_curr_addr=1 -> TX_GO.
- ECHO_BAD: en_out_byte=1, s_out_byte=3; err_count += 1, saturating at all-ones -> TX_GO.
- TX_GO: en/s_uart_tx_go=1/1 for exactly one cycle -> TX_WAIT.
- TX_WAIT:
  - Outputs: en/s_uart_tx_go=1/0; watchdog increments.
  - tx_done -> CHECK_END.
  - Watchdog reaches TX_TIMEOUT_CYCLES-1 -> CHECK_END and set tx_timeout.
  - Watchdog clears on leaving TX_WAIT.
- CHECK_END: end_of_game -> FINISH, else -> WAIT_KEY.
- FINISH: en/s_stopwatch_start=1/0 (freeze time) -> DONE.
- DONE:
  - Stopwatch frozen; no address change.
  - Transition: uart_pressed_eq_1 & start_of_game -> IDLE.
- RX strobes arriving outside WAIT_KEY/IDLE/DONE are dropped; no buffering.
- reset_eq_0==0 in any state forces IDLE next cycle; overrides all other transitions, including mid-TX.
- rst has priority over reset_eq_0.

Optional Feature:
- Macro TYPING_ERR_COUNT_EN.
- Defined: err_count behaves as above.
- Undefined: counter logic omitted; err_count tied to 0; ECHO_BAD still outputs 8'h2A.

Decomposition:
- Package typing_pkg holds:
  - state enumeration, 4-bit encoding
  - s_curr_addr codes: ADDR_CLR=0, ADDR_INC=1
  - s_out_byte codes: OUT_ZERO=0, OUT_ROM=1, OUT_RX=2, OUT_ERR=3
  - ERR_CHAR=8'h2A, ENTER_CHAR=8'h0D
- Sub-module tx_watchdog: counter with clear/enable and an expired output, parameterised by TX_TIMEOUT_CYCLES.

Test Plan:
- Reset, then Enter strobe (start_of_game=1) -> IDLE outputs held one cycle; next cycle ARM with s_stopwatch_rst=0; following cycle game_active=1.
- First key with stopwatch_start_eq_0_and_rom_eq_0=1 -> START_SW (s_stopwatch_start=1), ECHO_OK (s_out_byte=2, s_curr_addr=1), single-cycle s_uart_tx_go=1; tx_done after 50 cycles -> back to WAIT_KEY.
- Three keys with rom_eq_uart=0 -> three s_out_byte=3 echoes; err_count=3 (0 with TYPING_ERR_COUNT_EN undefined).
- tx_done withheld -> CHECK_END exactly TX_TIMEOUT_CYCLES cycles after TX_GO; tx_timeout=1 and remains set until the next ARM.
- end_of_game=1 after last echo -> FINISH (s_stopwatch_start=0), then game_done=1; a non-Enter key keeps DONE; Enter -> IDLE.
- reset_eq_0=0 during TX_WAIT -> IDLE next cycle, with stopwatch reset and address clear asserted.
